osc_decimator: RTL and testbench



---
 rtl/osc_pkg.sv | 17 +
 rtl/osc_dec_sat.sv | 33 +++
 rtl/osc_decimator.sv | 151 +++++++++++++++
 tb/tb_osc_decimator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared constants and width helpers for the oscilloscope decimation path
package osc_pkg;

  localparam int OSC_DW = 16;
  localparam int OSC_CW = 17;
  localparam int SHF_W  = 5;

  function automatic int acc_width(input int dw, input int cw);
    return dw + cw;
  endfunction

  localparam int OSC_AW        = acc_width(OSC_DW, OSC_CW);
  localparam int OSC_SAT_MAX   = (2 ** (OSC_DW - 1)) - 1;
  localparam int OSC_SAT_MIN   = -(2 ** (OSC_DW - 1));
  localparam int OSC_SHF_CLAMP = OSC_CW;

endpackage

// File: rtl/osc_dec_sat.sv
// rtl/osc_dec_sat.sv - arithmetic right shift of a wide signed sum with saturation to DW bits
module osc_dec_sat
  import osc_pkg::*;
#(
  parameter int DW = OSC_DW,
  parameter int CW = OSC_CW,
  parameter int AW = acc_width(OSC_DW, OSC_CW)
) (
  input  logic signed [AW-1:0]    sum_i,
  input  logic        [SHF_W-1:0] shift_i,
  output logic signed [DW-1:0]    sat_o
);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [SHF_W-1:0]     SHF_LIM = SHF_W'(CW);

  logic        [SHF_W-1:0] shf;
  logic signed [AW-1:0]    shifted;

  always_comb begin
    shf     = (shift_i > SHF_LIM) ? SHF_LIM : shift_i;
    shifted = sum_i >>> shf;
    if (shifted > SAT_MAX) begin
      sat_o = SAT_MAX[DW-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_o = SAT_MIN[DW-1:0];
    end else begin
      sat_o = shifted[DW-1:0];
    end
  end

endmodule

// File: rtl/osc_decimator.sv
// rtl/osc_decimator.sv - block decimator (last sample or shifted sum) with one-entry output buffer
module osc_decimator
  import osc_pkg::*;
#(
  parameter int DW = OSC_DW,
  parameter int CW = OSC_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [DW-1:0]    m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  input  logic [CW-1:0]    cfg_dec_factor,
  input  logic [SHF_W-1:0] cfg_dec_rshift,
  input  logic             cfg_avg_en,
  input  logic             cfg_restart,
  output logic             sts_overflow,
  input  logic             sts_ovf_clr
);

  localparam int AW = acc_width(DW, CW);

  logic        [CW-1:0]    cnt_q, cnt_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic        [CW-1:0]    fac_q, fac_d;
  logic        [SHF_W-1:0] shf_q, shf_d;
  logic                    avg_q, avg_d;
  logic        [DW-1:0]    tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    ovf_q, ovf_d;

  logic                    blk_start;
  logic        [CW-1:0]    fac_eff;
  logic        [SHF_W-1:0] shf_eff;
  logic                    avg_eff;
  logic signed [AW-1:0]    din_ext;
  logic signed [AW-1:0]    sum;
  logic        [CW:0]      cnt_inc;
  logic                    blk_end;
  logic                    accept;
  logic                    pop;
  logic                    ovf_set;
  logic signed [DW-1:0]    sat_out;
  logic        [DW-1:0]    result;

  // The first sample of a block sees the live config; later samples see the latched copy.
  always_comb begin
    blk_start = (cnt_q == '0);
    fac_eff   = blk_start ? ((cfg_dec_factor == '0) ? CW'(1) : cfg_dec_factor) : fac_q;
    shf_eff   = blk_start ? cfg_dec_rshift : shf_q;
    avg_eff   = blk_start ? cfg_avg_en : avg_q;
    din_ext   = {{(AW-DW){s_axis_tdata[DW-1]}}, s_axis_tdata};
    sum       = acc_q + din_ext;
    cnt_inc   = {1'b0, cnt_q} + 1'b1;
    blk_end   = !(cnt_inc < {1'b0, fac_eff});
    result    = avg_eff ? sat_out : s_axis_tdata;
  end

  osc_dec_sat #(
    .DW(DW),
    .CW(CW),
    .AW(AW)
  ) u_sat (
    .sum_i  (sum),
    .shift_i(shf_eff),
    .sat_o  (sat_out)
  );

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    fac_d    = fac_q;
    shf_d    = shf_q;
    avg_d    = avg_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovf_set  = 1'b0;
    accept   = s_axis_tvalid && !cfg_restart;
    pop      = tvalid_q && m_axis_tready;

    if (cfg_restart) begin
      cnt_d    = '0;
      acc_d    = '0;
      tvalid_d = 1'b0;
    end else begin
      if (pop) begin
        tvalid_d = 1'b0;
      end
      if (accept) begin
        if (blk_start) begin
          fac_d = fac_eff;
          shf_d = shf_eff;
          avg_d = avg_eff;
        end
        if (blk_end) begin
          cnt_d = '0;
          acc_d = '0;
          // A buffer being drained this cycle has room for the new result.
          if (!tvalid_q || m_axis_tready) begin
            tdata_d  = result;
            tvalid_d = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc[CW-1:0];
          acc_d = sum;
        end
      end
    end

    ovf_d = ovf_q;
    if (sts_ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      fac_q    <= CW'(1);
      shf_q    <= '0;
      avg_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      fac_q    <= fac_d;
      shf_q    <= shf_d;
      avg_q    <= avg_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign sts_overflow  = ovf_q;

endmodule

// File: tb/tb_osc_decimator.sv
// tb/tb_osc_decimator.sv - directed and random checks of osc_decimator against a block-level model
module tb_osc_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [16:0] cfg_dec_factor = 17'd1;
  logic [4:0]  cfg_dec_rshift = '0;
  logic        cfg_avg_en = 1'b0;
  logic        cfg_restart = 1'b0;
  logic        sts_overflow;
  logic        sts_ovf_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Model: samples of the open block, its latched config, and the output buffer.
  int          blk[$];
  int          m_fac = 1;
  int          m_shf = 0;
  logic        m_avg = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  osc_decimator dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .cfg_dec_factor(cfg_dec_factor),
    .cfg_dec_rshift(cfg_dec_rshift),
    .cfg_avg_en    (cfg_avg_en),
    .cfg_restart   (cfg_restart),
    .sts_overflow  (sts_overflow),
    .sts_ovf_clr   (sts_ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("tvalid", {31'b0, m_axis_tvalid}, {31'b0, m_valid});
    chk("tdata", {16'b0, m_axis_tdata}, {16'b0, m_data});
    chk("overflow", {31'b0, sts_overflow}, {31'b0, m_ovf});
  endtask

  function automatic logic [15:0] block_result(input logic [15:0] last);
    longint s;
    if (!m_avg) return last;
    s = 0;
    foreach (blk[i]) s += blk[i];
    s = s >>> m_shf;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic step(input logic v, input logic [15:0] d, input logic rdy,
                      input logic rs, input logic clr);
    logic        set;
    logic        nv;
    logic [15:0] res;
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = rdy;
    cfg_restart   = rs;
    sts_ovf_clr   = clr;
    set = 1'b0;
    nv  = m_valid && !rdy;
    if (rs) begin
      blk.delete();
      nv = 1'b0;
    end else if (v) begin
      if (blk.size() == 0) begin
        m_fac = (cfg_dec_factor == 0) ? 1 : int'(cfg_dec_factor);
        m_shf = (cfg_dec_rshift > 17) ? 17 : int'(cfg_dec_rshift);
        m_avg = cfg_avg_en;
      end
      blk.push_back(int'($signed(d)));
      if (blk.size() == m_fac) begin
        res = block_result(d);
        blk.delete();
        if (!m_valid || rdy) begin
          m_data = res;
          nv = 1'b1;
        end else begin
          set = 1'b1;
        end
      end
    end
    m_valid = nv;
    if (clr) m_ovf = 1'b0;
    if (set) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    step_no++;
    check_outputs();
  endtask

  task automatic set_cfg(input int fac, input int shf, input logic avg);
    cfg_dec_factor = 17'(fac);
    cfg_dec_rshift = 5'(shf);
    cfg_avg_en     = avg;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    cfg_restart   = 1'b0;
    sts_ovf_clr   = 1'b0;
    #2 rst = 1'b1;
    #1;
    blk.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_outputs();
    chk("tready_const", {31'b0, s_axis_tready}, 32'd1);
    rst = 1'b0;

    // Last-sample mode
    set_cfg(4, 0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
    chk("last_sample_out", {16'b0, m_axis_tdata}, 32'd8);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);

    // Average mode
    set_cfg(8, 3, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    chk("avg_max", {16'b0, m_axis_tdata}, 32'h7FFF);
    for (int i = 0; i < 8; i++) step(1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b0);
    chk("avg_neg3", {16'b0, m_axis_tdata}, 32'hFFFD);

    // Saturation
    set_cfg(4, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h7000, 1'b1, 1'b0, 1'b0);
    chk("sat_pos", {16'b0, m_axis_tdata}, 32'h7FFF);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h9000, 1'b1, 1'b0, 1'b0);
    chk("sat_neg", {16'b0, m_axis_tdata}, 32'h8000);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure, overflow, clear, set-wins-over-clear
    set_cfg(1, 0, 1'b0);
    step(1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'd20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'd30, 1'b0, 1'b0, 1'b0);
    chk("bp_hold", {16'b0, m_axis_tdata}, 32'd10);
    chk("bp_ovf", {31'b0, sts_overflow}, 32'd1);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", {31'b0, sts_overflow}, 32'd0);
    step(1'b1, 16'd50, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", {31'b0, sts_overflow}, 32'd1);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);

    // Mid-block config change, then restart
    set_cfg(4, 0, 1'b0);
    step(1'b1, 16'd11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd12, 1'b1, 1'b0, 1'b0);
    set_cfg(2, 0, 1'b0);
    step(1'b1, 16'd13, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd14, 1'b1, 1'b0, 1'b0);
    chk("cfg_latched", {16'b0, m_axis_tdata}, 32'd14);
    step(1'b1, 16'd15, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd16, 1'b1, 1'b0, 1'b0);
    chk("cfg_new_fac", {16'b0, m_axis_tdata}, 32'd16);
    step(1'b1, 16'd17, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd18, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd19, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd20, 1'b1, 1'b0, 1'b0);
    chk("restart_recount", {16'b0, m_axis_tdata}, 32'd20);

    // Restart overrides a block end
    set_cfg(1, 0, 1'b0);
    step(1'b1, 16'd99, 1'b0, 1'b1, 1'b0);
    chk("restart_no_out", {31'b0, m_axis_tvalid}, 32'd0);

    // Factor 0 with input gaps
    set_cfg(0, 0, 1'b1);
    step(1'b1, 16'd5, 1'b1, 1'b0, 1'b0);
    chk("fac0_first", {16'b0, m_axis_tdata}, 32'd5);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd6, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);

    // Async reset mid-block
    set_cfg(4, 0, 1'b0);
    step(1'b1, 16'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd2, 1'b1, 1'b0, 1'b0);
    mid_reset();
    for (int i = 3; i <= 7; i++) step(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);

    // Randomized traffic with random config, backpressure, restarts and clears
    for (int n = 0; n < 600; n++) begin
      if (n % 25 == 0) set_cfg($urandom_range(0, 5), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 20) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
